ram_bank: RTL and testbench

Parametrised single-port synchronous RAM bank with per-byte write enables, a registered read path with a valid strobe, out-of-range detection, and a hardware clear sweep on reset. It replaces the fixed 32-bit RAM as the general storage primitive for register files, scratchpads and small buffers. A write/read pair is accepted every cycle once the post-reset clear has finished.

---
 rtl/ram_bank.sv | 123 ++++++++++++
 tb/tb_ram_bank.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bank.sv
// Single-port synchronous RAM bank with byte enables, registered read, range check and clear sweep.
// Build option: define RAM_BYPASS_EN for write-first same-address read+write (read-first otherwise).
module ram_bank #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                read,
  input  logic                write,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   data,
  input  logic [DATA_W/8-1:0] byte_en,
  output logic [DATA_W-1:0]   read_data,
  output logic                read_valid,
  output logic                addr_err,
  output logic                busy
);

  localparam int unsigned NumBytes = DATA_W / 8;
  localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [0:0] {StClear, StReady} state_e;

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [IdxW-1:0]   clr_idx_q, clr_idx_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic              read_valid_q, read_valid_d;
  logic              addr_err_q, addr_err_d;

  logic              in_range;
  logic [IdxW-1:0]   word_idx;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] merged_word;
  logic [DATA_W-1:0] rd_word;
  logic              mem_we;
  logic [IdxW-1:0]   mem_idx;
  logic [DATA_W-1:0] mem_wdata;

  // Full-width compare so high address bits never alias into the array.
  assign in_range = (64'(address) < 64'(DEPTH));
  assign word_idx = IdxW'(address);
  assign old_word = mem[word_idx];

  always_comb begin
    merged_word = old_word;
    for (int i = 0; i < NumBytes; i++) begin
      if (byte_en[i]) begin
        merged_word[8*i +: 8] = data[8*i +: 8];
      end
    end
  end

`ifdef RAM_BYPASS_EN
  assign rd_word = write ? merged_word : old_word;
`else
  assign rd_word = old_word;
`endif

  always_comb begin
    state_d      = state_q;
    clr_idx_d    = clr_idx_q;
    read_data_d  = read_data_q;
    read_valid_d = 1'b0;
    addr_err_d   = 1'b0;
    mem_we       = 1'b0;
    mem_idx      = word_idx;
    mem_wdata    = merged_word;
    unique case (state_q)
      StClear: begin
        mem_we    = 1'b1;
        mem_idx   = clr_idx_q;
        mem_wdata = '0;
        clr_idx_d = clr_idx_q + IdxW'(1);
        if (clr_idx_q == IdxW'(DEPTH - 1)) begin
          state_d   = StReady;
          clr_idx_d = '0;
        end
      end
      StReady: begin
        mem_we     = write & in_range;
        addr_err_d = (read | write) & ~in_range;
        if (read) begin
          read_valid_d = 1'b1;
          read_data_d  = in_range ? rd_word : '0;
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StClear;
      clr_idx_q    <= '0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      addr_err_q   <= addr_err_d;
    end
  end

  // Storage has no reset; it is only zeroed by the sweep.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[mem_idx] <= mem_wdata;
    end
  end

  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;
  assign addr_err   = addr_err_q;
  assign busy       = (state_q == StClear);

endmodule

// File: tb/tb_ram_bank.sv
// Self-checking bench for ram_bank (DEPTH=16, DATA_W=32) against a word-array reference model.
module tb_ram_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        read;
  logic        write;
  logic [31:0] address;
  logic [31:0] data;
  logic [3:0]  byte_en;
  logic [31:0] read_data;
  logic        read_valid;
  logic        addr_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m [16];
  logic [31:0] exp_rd;
  logic        exp_valid;
  logic        exp_err;

  ram_bank #(.DATA_W(32), .DEPTH(16), .ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .read       (read),
    .write      (write),
    .address    (address),
    .data       (data),
    .byte_en    (byte_en),
    .read_data  (read_data),
    .read_valid (read_valid),
    .addr_err   (addr_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One READY-state request; updates the model and the expected outputs.
  task automatic apply(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    logic [31:0] old;
    logic [31:0] merged;
    logic        oor;
    read = rd; write = wr; address = a; data = d; byte_en = be;
    oor = (a >= 32'd16);
    old = oor ? 32'h0 : mem_m[a[3:0]];
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = be[i] ? d[8*i +: 8] : old[8*i +: 8];
    end
    exp_valid = rd;
    exp_err   = (rd | wr) & oor;
    if (rd) begin
      if (oor) exp_rd = 32'h0;
`ifdef RAM_BYPASS_EN
      else exp_rd = wr ? merged : old;
`else
      else exp_rd = old;
`endif
    end
    if (wr && !oor) mem_m[a[3:0]] = merged;
    step();
    read = 1'b0; write = 1'b0;
  endtask

  task automatic do_reset();
    read = 1'b0; write = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    exp_rd = 32'h0; exp_valid = 1'b0; exp_err = 1'b0;
    for (int i = 0; i < 16; i++) mem_m[i] = 32'h0;
  endtask

  // Steps up to n edges with random ignored requests; returns how many edges left busy high.
  task automatic sweep(input int n, output int busy_cycles, output int stray);
    busy_cycles = 0;
    stray = 0;
    for (int k = 0; k < n; k++) begin
      read = 1'($urandom); write = 1'($urandom); address = $urandom_range(0, 20);
      data = $urandom; byte_en = 4'($urandom);
      step();
      if (busy) busy_cycles++;
      if (read_valid || addr_err) stray++;
    end
    read = 1'b0; write = 1'b0;
  endtask

  task automatic test_reset();
    int bc, st;
    do_reset();
    checks++;
    if ({busy, read_valid, addr_err, read_data} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_state busy=%b valid=%b err=%b rd=%h required 1 0 0 0",
               busy, read_valid, addr_err, read_data);
    end
    sweep(16, bc, st);
    checks++;
    if (bc !== 15 || busy !== 1'b0) begin
      errors++; $display("FAIL sweep_len busy_after_edges=%0d busy=%b required 15 0", bc, busy);
    end
    checks++;
    if (st !== 0) begin
      errors++; $display("FAIL busy_ignored stray_pulses=%0d required 0", st);
    end
    for (int a = 0; a < 16; a++) begin
      apply(1'b1, 1'b0, a, 32'h0, 4'h0);
      checks++;
      if (read_data !== 32'h0 || read_valid !== 1'b1 || addr_err !== 1'b0) begin
        errors++;
        $display("FAIL cleared_read a=%0d rd=%h valid=%b err=%b required 0 1 0",
                 a, read_data, read_valid, addr_err);
      end
    end
  endtask

  task automatic test_byte_en();
    apply(1'b0, 1'b1, 32'd3, 32'h12345678, 4'b1111);
    apply(1'b0, 1'b1, 32'd3, 32'hAABBCCDD, 4'b0101);
    apply(1'b1, 1'b0, 32'd3, 32'h0, 4'h0);
    checks++;
    if (read_data !== 32'h12BB56DD || read_valid !== 1'b1) begin
      errors++; $display("FAIL byte_en rd=%h valid=%b required 12bb56dd 1", read_data, read_valid);
    end
    apply(1'b0, 1'b0, 32'd0, 32'h0, 4'h0);
    checks++;
    if (read_valid !== 1'b0 || read_data !== 32'h12BB56DD) begin
      errors++; $display("FAIL valid_pulse valid=%b rd=%h required 0 12bb56dd", read_valid, read_data);
    end
  endtask

  task automatic test_out_of_range();
    apply(1'b1, 1'b0, 32'd16, 32'h0, 4'h0);
    checks++;
    if (read_data !== 32'h0 || read_valid !== 1'b1 || addr_err !== 1'b1) begin
      errors++;
      $display("FAIL oor_read rd=%h valid=%b err=%b required 0 1 1", read_data, read_valid, addr_err);
    end
    apply(1'b0, 1'b1, 32'h00000013, 32'hDEADBEEF, 4'hF);
    checks++;
    if (addr_err !== 1'b1 || read_valid !== 1'b0) begin
      errors++; $display("FAIL oor_write err=%b valid=%b required 1 0", addr_err, read_valid);
    end
    apply(1'b0, 1'b1, 32'h80000003, 32'hDEADBEEF, 4'hF);
    apply(1'b1, 1'b0, 32'd3, 32'h0, 4'h0);
    checks++;
    if (read_data !== 32'h12BB56DD || addr_err !== 1'b0) begin
      errors++; $display("FAIL oor_no_alias rd=%h err=%b required 12bb56dd 0", read_data, addr_err);
    end
  endtask

  task automatic test_same_addr();
    logic [31:0] want;
`ifdef RAM_BYPASS_EN
    want = 32'h0000FFFF;
`else
    want = 32'h0000000F;
`endif
    apply(1'b0, 1'b1, 32'd5, 32'h0000000F, 4'hF);
    apply(1'b1, 1'b1, 32'd5, 32'hFFFFFFFF, 4'b0011);
    checks++;
    if (read_data !== want || read_valid !== 1'b1) begin
      errors++; $display("FAIL same_addr rd=%h required %h", read_data, want);
    end
    apply(1'b1, 1'b0, 32'd5, 32'h0, 4'h0);
    checks++;
    if (read_data !== 32'h0000FFFF) begin
      errors++; $display("FAIL same_addr_after rd=%h required 0000ffff", read_data);
    end
  endtask

  task automatic test_reset_restart();
    int bc, st;
    do_reset();
    sweep(7, bc, st);
    do_reset();
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL restart_busy busy=%b required 1", busy);
    end
    sweep(16, bc, st);
    checks++;
    if (bc !== 15 || busy !== 1'b0 || st !== 0) begin
      errors++; $display("FAIL restart_sweep busy_edges=%0d busy=%b stray=%0d required 15 0 0",
                         bc, busy, st);
    end
    apply(1'b0, 1'b1, 32'd1, 32'h11111111, 4'hF);
    apply(1'b0, 1'b1, 32'd2, 32'h22222222, 4'hF);
    apply(1'b1, 1'b0, 32'd20, 32'h0, 4'h0);
    checks++;
    if (read_valid !== 1'b1 || addr_err !== 1'b1) begin
      errors++; $display("FAIL pre_reset_pulse valid=%b err=%b required 1 1", read_valid, addr_err);
    end
    do_reset();
    checks++;
    if (read_valid !== 1'b0 || addr_err !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL reset_clears valid=%b err=%b busy=%b required 0 0 1",
                         read_valid, addr_err, busy);
    end
    sweep(16, bc, st);
    for (int a = 1; a <= 2; a++) begin
      apply(1'b1, 1'b0, a, 32'h0, 4'h0);
      checks++;
      if (read_data !== 32'h0 || read_valid !== 1'b1) begin
        errors++; $display("FAIL restart_cleared a=%0d rd=%h required 0", a, read_data);
      end
    end
  endtask

  task automatic test_back_to_back();
    apply(1'b0, 1'b1, 32'd0, 32'hA, 4'hF);
    apply(1'b0, 1'b1, 32'd1, 32'hB, 4'hF);
    apply(1'b0, 1'b1, 32'd2, 32'hC, 4'hF);
    for (int a = 0; a < 3; a++) begin
      read = 1'b1; address = a;
      step();
      checks++;
      if (read_data !== 32'hA + a || read_valid !== 1'b1) begin
        errors++; $display("FAIL back_to_back a=%0d rd=%h valid=%b required %h 1",
                           a, read_data, read_valid, 32'hA + a);
      end
    end
    read = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      apply(1'($urandom), 1'($urandom), $urandom_range(0, 19), $urandom, 4'($urandom));
      checks++;
      if (read_data !== exp_rd || read_valid !== exp_valid || addr_err !== exp_err
          || busy !== 1'b0) begin
        errors++;
        $display("FAIL random n=%0d rd=%h valid=%b err=%b busy=%b required %h %b %b 0",
                 n, read_data, read_valid, addr_err, busy, exp_rd, exp_valid, exp_err);
      end
    end
  endtask

  initial begin
    reset = 1'b0; read = 1'b0; write = 1'b0;
    address = '0; data = '0; byte_en = '0;
    step();
    test_reset();
    test_byte_en();
    test_out_of_range();
    test_same_addr();
    test_random();
    test_reset_restart();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
